// File: rtl/out_display.sv
// out_display
//
// Output-side companion to the CPU. Filters the CPU's 4-bit `out` bus for
// stability, commits each newly settled value into a 4-entry history, and
// scans that history in hex onto a 4-digit multiplexed seven-segment display.
//
// Parameters:
//   SCAN_DIV  clock cycles each digit stays enabled (>= 2)
//   STABLE    consecutive identical samples needed to commit a value (>= 1)
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   out_in     in   CPU `out` bus (4 bits)
//   seg        out  segments {g,f,e,d,c,b,a}, active-low
//   an         out  digit enables, active-low one-hot, an[k] = digit k
//   chg_pulse  out  one-cycle pulse on every commit
//   hist_cnt   out  saturating count of commits (0..255)

module out_display #(
  parameter int SCAN_DIV = 1024,
  parameter int STABLE   = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] out_in,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       chg_pulse,
  output logic [7:0] hist_cnt
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(STABLE + 1);

  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STAB_MAX   = SW'(STABLE);
  localparam logic [SW-1:0] STAB_ALMOST = SW'(STABLE - 1);

  logic [3:0]    sample;
  logic [3:0]    candidate;
  logic [SW-1:0] stab_cnt;
  logic [3:0]    hist [4];
  logic [PW-1:0] prescaler;
  logic [1:0]    digit;

  logic load;
  logic settle;
  logic commit;

  // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A new candidate restarts the stability count at 1, so with STABLE=1 the
  // load edge itself is the settling edge. Otherwise the value settles on the
  // edge where the count steps from STABLE-1 to STABLE. In both cases the
  // settling value equals `sample`.
  always_comb begin
    load   = (sample != candidate);
    settle = load ? (STABLE == 1) : (stab_cnt == STAB_ALMOST);
    commit = settle && (sample != hist[0]);
  end

  // Sampler, stability filter and history shift register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample    <= '0;
      candidate <= '0;
      stab_cnt  <= '0;
      hist[0]   <= '0;
      hist[1]   <= '0;
      hist[2]   <= '0;
      hist[3]   <= '0;
      chg_pulse <= 1'b0;
      hist_cnt  <= '0;
    end else begin
      sample <= out_in;
      if (load) begin
        candidate <= sample;
        stab_cnt  <= SW'(1);
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + SW'(1);
      end
      chg_pulse <= commit;
      if (commit) begin
        hist[3] <= hist[2];
        hist[2] <= hist[1];
        hist[1] <= hist[0];
        hist[0] <= sample;
        if (hist_cnt != 8'hFF) begin
          hist_cnt <= hist_cnt + 8'd1;
        end
      end
    end
  end

  // Digit scanner. an/seg are registered from the current digit and history,
  // so a digit change or history update shows up one edge later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      digit     <= '0;
      an        <= 4'b1111;
      seg       <= 7'h7F;
    end else begin
      if (prescaler == PRE_LAST) begin
        prescaler <= '0;
        digit     <= digit + 2'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
      an  <= ~(4'b0001 << digit);
      seg <= hex_to_seg(hist[digit]);
    end
  end

endmodule

// File: tb/tb_out_display.sv
// tb_out_display
//
// Self-checking bench for out_display (SCAN_DIV=4, STABLE=2). Stimulus pushes
// the expected hist_cnt of every commit it causes into a queue; a monitor pops
// and compares on each chg_pulse and flags any pulse nobody asked for.
// Directed checks cover reset, scan order, commit latency and digit contents.

module tb_out_display;

  localparam int SCAN_DIV = 4;
  localparam int STABLE   = 2;

  logic       clock;
  logic       reset_n;
  logic [3:0] out_in;
  logic [6:0] seg;
  logic [3:0] an;
  logic       chg_pulse;
  logic [7:0] hist_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  out_display #(
    .SCAN_DIV(SCAN_DIV),
    .STABLE  (STABLE)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .out_in   (out_in),
    .seg      (seg),
    .an       (an),
    .chg_pulse(chg_pulse),
    .hist_cnt (hist_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive a value at a falling edge and hold it for the given cycles.
  task automatic apply_stimulus(input logic [3:0] val, input int cycles);
    out_in = val;
    repeat (cycles) @(negedge clock);
  endtask

  // Wait (bounded) until digit d is enabled, then check its segments.
  task automatic check_digit(input int d, input logic [6:0] exp_seg, input string name);
    logic [3:0] tgt;
    bit found;
    tgt   = ~(4'b0001 << d);
    found = 0;
    for (int i = 0; i < 4 * SCAN_DIV + 4 && !found; i++) begin
      @(negedge clock);
      if (an === tgt) found = 1;
    end
    if (found) begin
      check_output(name, {1'b0, seg}, {1'b0, exp_seg});
    end else begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: digit %0d never enabled, an=%b", name, d, an);
    end
  endtask

  // Scoreboard monitor: every pulse must match a queued commit.
  always @(negedge clock) begin
    if (reset_n && chg_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse: got pulse with hist_cnt=%0d, expected none at %0t",
                 hist_cnt, $time);
      end else begin
        check_output("pulse_hist_cnt", hist_cnt, 8'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    out_in  = 4'h0;

    // Reset values while held in reset.
    #12;
    check_output("reset_an",   {4'h0, an}, 8'h0F);
    check_output("reset_seg",  {1'b0, seg}, 8'h7F);
    check_output("reset_chg",  {7'h0, chg_pulse}, 8'h00);
    check_output("reset_cnt",  hist_cnt, 8'h00);

    // Release at a falling edge, then follow the scan: each digit 4 edges.
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] exp_an;
      @(posedge clock);
      #1;
      exp_an = ~(4'b0001 << (((k - 1) / SCAN_DIV) % 4));
      check_output("scan_an", {4'h0, an}, {4'h0, exp_an});
      if (k == 1) check_output("first_seg", {1'b0, seg}, 8'h40);
    end

    // 0 -> 5: pulse exactly at edge n+2.
    @(negedge clock);
    exp_q.push_back(1);
    out_in = 4'h5;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      check_output("commit_latency", {7'h0, chg_pulse}, (k == 2) ? 8'h01 : 8'h00);
    end
    check_output("cnt_after_5", hist_cnt, 8'd1);
    check_digit(0, 7'h12, "digit0_5");

    // One-cycle glitch to 9 and back to 5: no commit.
    @(negedge clock);
    apply_stimulus(4'h9, 1);
    apply_stimulus(4'h5, 10);
    check_output("glitch_cnt", hist_cnt, 8'd1);
    check_digit(0, 7'h12, "glitch_digit0");

    // Asynchronous reset while 7 is pending a commit.
    out_in = 4'h7;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_an",  {4'h0, an}, 8'h0F);
    check_output("async_seg", {1'b0, seg}, 8'h7F);
    check_output("async_chg", {7'h0, chg_pulse}, 8'h00);
    check_output("async_cnt", hist_cnt, 8'h00);
    out_in = 4'h0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check_output("post_reset_cnt", hist_cnt, 8'h00);
    check_digit(0, 7'h40, "post_reset_digit0");

    // Five settled values fill the history with {5,4,3,2}.
    @(negedge clock);
    for (int v = 1; v <= 5; v++) begin
      exp_q.push_back(v);
      apply_stimulus(4'(v), 10);
    end
    check_output("hist_cnt_5", hist_cnt, 8'd5);
    check_digit(0, 7'h12, "hist_digit0");
    check_digit(1, 7'h19, "hist_digit1");
    check_digit(2, 7'h30, "hist_digit2");
    check_digit(3, 7'h24, "hist_digit3");

    // 300 alternating commits saturate the counter at 255.
    @(negedge clock);
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back((6 + i > 255) ? 255 : 6 + i);
      apply_stimulus((i % 2 == 0) ? 4'hA : 4'hB, 3);
    end
    apply_stimulus(4'hB, 50);
    check_output("saturated_cnt", hist_cnt, 8'd255);
    check_digit(0, 7'h03, "final_digit0_b");
    check_digit(1, 7'h08, "final_digit1_a");
    check_output("pending_commits", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
